// File: rtl/wb_arbiter_2m_if.sv
// One Wishbone link: the arbiter takes two of these as slave-side ports
// (one per master) and drives a third, master-side, toward the shared slave.
interface wb_arbiter_2m_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic        ack;
  logic        err;

  // The shared slave reports no error, so the master side does not take err in.
  modport master (
    output cyc, stb, we, addr, dat_w, sel, cti,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, addr, dat_w, sel, cti,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Round-robin two-master Wishbone arbiter in front of a single slave (SDRAM port),
// with a per-transfer wait timeout that aborts a stuck cycle and signals err.
module wb_arbiter_2m #(
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_arbiter_2m_if.slave         m0,
  wb_arbiter_2m_if.slave         m1,
  wb_arbiter_2m_if.master        s,
  output logic [1:0]             grant_o
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1,
    ABORT
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        rr_last;
  logic        rr_last_next;
  logic        owner;
  logic        owner_next;
  logic [15:0] wait_cnt;
  logic [15:0] wait_cnt_next;

  logic        in_grant;
  logic        timeout_hit;
  logic        sel_cyc;
  logic        sel_stb;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_dat;
  logic [3:0]  sel_sel;
  logic [2:0]  sel_cti;

  // The owner register selects which master's request is forwarded; it is
  // only meaningful in GNT0/GNT1/ABORT.
  always_comb begin
    sel_cyc  = m0.cyc;
    sel_stb  = m0.stb;
    sel_we   = m0.we;
    sel_addr = m0.addr;
    sel_dat  = m0.dat_w;
    sel_sel  = m0.sel;
    sel_cti  = m0.cti;
    if (owner) begin
      sel_cyc  = m1.cyc;
      sel_stb  = m1.stb;
      sel_we   = m1.we;
      sel_addr = m1.addr;
      sel_dat  = m1.dat_w;
      sel_sel  = m1.sel;
      sel_cti  = m1.cti;
    end
  end

  assign in_grant    = (state == GNT0) || (state == GNT1);
  assign timeout_hit = in_grant && sel_cyc && sel_stb && !s.ack &&
                       (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      rr_last  <= 1'b1;
      owner    <= 1'b0;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_next;
      rr_last  <= rr_last_next;
      owner    <= owner_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // On a tie, master 0 wins unless it was the last one served.
  always_comb begin
    state_next   = state;
    rr_last_next = rr_last;
    owner_next   = owner;
    unique case (state)
      IDLE: begin
        if (m0.cyc && (!m1.cyc || rr_last)) begin
          state_next   = GNT0;
          rr_last_next = 1'b0;
          owner_next   = 1'b0;
        end else if (m1.cyc) begin
          state_next   = GNT1;
          rr_last_next = 1'b1;
          owner_next   = 1'b1;
        end
      end
      GNT0, GNT1: begin
        if (!sel_cyc) begin
          state_next = IDLE;
        end else if (timeout_hit) begin
          state_next = ABORT;
        end
      end
      ABORT: begin
        if (!sel_cyc) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    wait_cnt_next = 16'd0;
    if (in_grant && sel_stb && !s.ack) begin
      wait_cnt_next = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
    end
  end

  // Read data is broadcast; only the owner ever sees ack, so the other master ignores it.
  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.addr   = 32'd0;
    s.dat_w  = 32'd0;
    s.sel    = 4'd0;
    s.cti    = 3'd0;
    m0.dat_r = s.dat_r;
    m1.dat_r = s.dat_r;
    m0.ack   = 1'b0;
    m1.ack   = 1'b0;
    m0.err   = 1'b0;
    m1.err   = 1'b0;
    grant_o  = 2'b00;
    if (in_grant) begin
      s.cyc   = sel_cyc;
      s.stb   = sel_stb;
      s.we    = sel_we;
      s.addr  = sel_addr;
      s.dat_w = sel_dat;
      s.sel   = sel_sel;
      s.cti   = sel_cti;
      if (owner) begin
        m1.ack = s.ack;
        m1.err = timeout_hit && !wb_rst_i;
      end else begin
        m0.ack = s.ack;
        m0.err = timeout_hit && !wb_rst_i;
      end
    end
    if (in_grant || (state == ABORT)) begin
      grant_o = owner ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m (TIMEOUT=8): single transfer, round-robin
// ties, burst hold, timeout abort, ack-wins-timeout and mid-burst reset.
module tb_wb_arbiter_2m;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i;
  logic [1:0] grant_o;
  int         compared   = 0;
  int         mismatched = 0;

  wb_arbiter_2m_if m0_if ();
  wb_arbiter_2m_if m1_if ();
  wb_arbiter_2m_if s_if ();

  wb_arbiter_2m #(.TIMEOUT(8)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .m0       (m0_if),
    .m1       (m1_if),
    .s        (s_if),
    .grant_o  (grant_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic apply_stimulus(input int n, input logic cyc, input logic stb,
                                input logic we, input logic [31:0] addr,
                                input logic [31:0] dat, input logic [3:0] sel,
                                input logic [2:0] cti);
    if (n == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we; m0_if.addr = addr;
      m0_if.dat_w = dat; m0_if.sel = sel; m0_if.cti = cti;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we; m1_if.addr = addr;
      m1_if.dat_w = dat; m1_if.sel = sel; m1_if.cti = cti;
    end
  endtask

  initial begin
    wb_rst_i = 1'b1;
    apply_stimulus(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    apply_stimulus(1, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    s_if.ack   = 1'b0;
    s_if.dat_r = 32'd0;
    s_if.err   = 1'b0;
    tick();
    tick();
    wb_rst_i = 1'b0;
    #1;
    check_output("rst_grant", grant_o, 32'd0);
    check_output("rst_s_cyc", s_if.cyc, 32'd0);
    check_output("rst_s_stb", s_if.stb, 32'd0);
    check_output("rst_m0_err", m0_if.err, 32'd0);
    s_if.dat_r = 32'hA5A5_5A5A;
    s_if.ack   = 1'b1;
    #1;
    check_output("idle_m0_dat", m0_if.dat_r, 32'hA5A5_5A5A);
    check_output("idle_m1_dat", m1_if.dat_r, 32'hA5A5_5A5A);
    check_output("idle_ack_m0", m0_if.ack, 32'd0);
    check_output("idle_ack_m1", m1_if.ack, 32'd0);
    s_if.ack = 1'b0;

    // m0 single write, three wait cycles then ack
    tick();
    apply_stimulus(0, 1, 1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b000);
    #1;
    check_output("wr_arb_s_cyc", s_if.cyc, 32'd0);
    check_output("wr_arb_grant", grant_o, 32'd0);
    tick();
    #1;
    check_output("wr_s_cyc", s_if.cyc, 32'd1);
    check_output("wr_s_addr", s_if.addr, 32'h0000_0010);
    check_output("wr_s_dat", s_if.dat_w, 32'hDEAD_BEEF);
    check_output("wr_s_we", s_if.we, 32'd1);
    check_output("wr_s_sel", s_if.sel, 32'hF);
    check_output("wr_grant", grant_o, 32'd1);
    check_output("wr_wait_ack", m0_if.ack, 32'd0);
    tick();
    tick();
    tick();
    s_if.ack = 1'b1;
    #1;
    check_output("wr_m0_ack", m0_if.ack, 32'd1);
    check_output("wr_m1_ack", m1_if.ack, 32'd0);
    check_output("wr_m0_err", m0_if.err, 32'd0);
    tick();
    s_if.ack = 1'b0;
    apply_stimulus(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    #1;
    check_output("wr_drop_s_cyc", s_if.cyc, 32'd0);
    check_output("wr_drop_ack", m0_if.ack, 32'd0);
    check_output("wr_drop_grant", grant_o, 32'd1);
    tick();
    #1;
    check_output("wr_end_grant", grant_o, 32'd0);

    // simultaneous requests after reset
    wb_rst_i = 1'b1;
    tick();
    wb_rst_i = 1'b0;
    apply_stimulus(0, 1, 1, 0, 32'h0000_0200, 32'd0, 4'hF, 3'b000);
    apply_stimulus(1, 1, 1, 0, 32'h0000_0300, 32'd0, 4'hF, 3'b000);
    #1;
    check_output("tie_arb_grant", grant_o, 32'd0);
    tick();
    #1;
    check_output("tie_grant_m0", grant_o, 32'd1);
    check_output("tie_addr_m0", s_if.addr, 32'h0000_0200);
    s_if.ack = 1'b1;
    #1;
    check_output("tie_ack_m0", m0_if.ack, 32'd1);
    check_output("tie_noack_m1", m1_if.ack, 32'd0);
    tick();
    s_if.ack = 1'b0;
    apply_stimulus(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    tick();
    #1;
    check_output("tie_one_idle", grant_o, 32'd0);
    check_output("tie_idle_s_cyc", s_if.cyc, 32'd0);
    tick();
    #1;
    check_output("tie_grant_m1", grant_o, 32'd2);
    check_output("tie_addr_m1", s_if.addr, 32'h0000_0300);
    s_if.ack = 1'b1;
    #1;
    check_output("tie_ack_m1", m1_if.ack, 32'd1);
    check_output("tie_noack_m0", m0_if.ack, 32'd0);
    tick();
    s_if.ack = 1'b0;
    apply_stimulus(1, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    tick();
    apply_stimulus(0, 1, 1, 0, 32'h0000_0200, 32'd0, 4'hF, 3'b000);
    apply_stimulus(1, 1, 1, 0, 32'h0000_0300, 32'd0, 4'hF, 3'b000);
    tick();
    #1;
    check_output("tie_again_m0", grant_o, 32'd1);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    apply_stimulus(1, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    tick();

    // m1 four-beat read burst while m0 requests mid-burst
    apply_stimulus(1, 1, 1, 0, 32'h0000_0400, 32'd0, 4'hF, 3'b010);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 1, 1, 0, 32'h0000_0400 + 32'(4 * i), 32'd0, 4'hF,
                     (i == 3) ? 3'b111 : 3'b010);
      s_if.ack   = 1'b1;
      s_if.dat_r = 32'(i + 1);
      if (i == 1) begin
        apply_stimulus(0, 1, 1, 1, 32'h0000_0500, 32'h0000_0055, 4'hF, 3'b000);
      end
      #1;
      check_output($sformatf("burst_ack_%0d", i), m1_if.ack, 32'd1);
      check_output($sformatf("burst_dat_%0d", i), m1_if.dat_r, 32'(i + 1));
      check_output($sformatf("burst_m0_ack_%0d", i), m0_if.ack, 32'd0);
      check_output($sformatf("burst_grant_%0d", i), grant_o, 32'd2);
      check_output($sformatf("burst_cti_%0d", i), s_if.cti, (i == 3) ? 32'd7 : 32'd2);
      tick();
    end
    s_if.ack = 1'b0;
    apply_stimulus(1, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    #1;
    check_output("burst_drop_grant", grant_o, 32'd2);
    check_output("burst_drop_s_cyc", s_if.cyc, 32'd0);
    tick();
    #1;
    check_output("burst_idle_grant", grant_o, 32'd0);
    tick();
    #1;
    check_output("burst_m0_grant", grant_o, 32'd1);
    check_output("burst_m0_addr", s_if.addr, 32'h0000_0500);
    tick();
    apply_stimulus(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    tick();

    // m0 read with no ack from the slave: timeout abort
    apply_stimulus(0, 1, 1, 0, 32'h0000_0600, 32'd0, 4'hF, 3'b000);
    tick();
    for (int w = 1; w <= 8; w++) begin
      #1;
      check_output($sformatf("to_err_w%0d", w), m0_if.err, (w == 8) ? 32'd1 : 32'd0);
      check_output($sformatf("to_ack_w%0d", w), m0_if.ack, 32'd0);
      check_output($sformatf("to_m1_ack_w%0d", w), m1_if.ack, 32'd0);
      tick();
    end
    #1;
    check_output("abort_s_cyc", s_if.cyc, 32'd0);
    check_output("abort_s_stb", s_if.stb, 32'd0);
    check_output("abort_grant", grant_o, 32'd1);
    check_output("abort_err", m0_if.err, 32'd0);
    s_if.ack = 1'b1;
    #1;
    check_output("abort_ack_ignored", m0_if.ack, 32'd0);
    tick();
    s_if.ack = 1'b0;
    #1;
    check_output("abort_hold_grant", grant_o, 32'd1);
    apply_stimulus(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    tick();
    #1;
    check_output("abort_idle_grant", grant_o, 32'd0);

    // ack in the eighth wait cycle beats the timeout
    apply_stimulus(0, 1, 1, 0, 32'h0000_0610, 32'd0, 4'hF, 3'b000);
    tick();
    for (int w = 1; w <= 7; w++) begin
      #1;
      check_output($sformatf("race_err_w%0d", w), m0_if.err, 32'd0);
      tick();
    end
    s_if.ack = 1'b1;
    #1;
    check_output("race_ack", m0_if.ack, 32'd1);
    check_output("race_no_err", m0_if.err, 32'd0);
    tick();
    s_if.ack = 1'b0;
    #1;
    check_output("race_still_granted", grant_o, 32'd1);
    check_output("race_s_cyc", s_if.cyc, 32'd1);
    apply_stimulus(0, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    tick();
    #1;
    check_output("race_idle_grant", grant_o, 32'd0);

    // reset during beat 2 of an m1 burst, followed by a late ack
    apply_stimulus(1, 1, 1, 0, 32'h0000_0700, 32'd0, 4'hF, 3'b010);
    tick();
    s_if.ack   = 1'b1;
    s_if.dat_r = 32'd1;
    #1;
    check_output("rstb_beat1_ack", m1_if.ack, 32'd1);
    tick();
    wb_rst_i   = 1'b1;
    s_if.dat_r = 32'd2;
    #1;
    check_output("rstb_m0_err", m0_if.err, 32'd0);
    check_output("rstb_m1_err", m1_if.err, 32'd0);
    tick();
    wb_rst_i   = 1'b0;
    s_if.dat_r = 32'd3;
    #1;
    check_output("rstb_s_cyc", s_if.cyc, 32'd0);
    check_output("rstb_grant", grant_o, 32'd0);
    check_output("rstb_late_ack_m1", m1_if.ack, 32'd0);
    check_output("rstb_late_ack_m0", m0_if.ack, 32'd0);
    check_output("rstb_no_err", m1_if.err, 32'd0);
    apply_stimulus(1, 0, 0, 0, 32'd0, 32'd0, 4'd0, 3'd0);
    s_if.ack = 1'b0;
    tick();
    #1;
    check_output("rstb_end_grant", grant_o, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_2m.md
WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

Interface
REQ-001 Parameter: TIMEOUT, default 256, number of wait cycles without s_ack_i before a transfer is aborted; valid range 2..65535.
REQ-002 wb_clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 wb_rst_i  input  1  reset; synchronous and active-high.
REQ-004 mN_cyc_i  input  1  cycle valid from master N (N = 0, 1).
REQ-005 mN_stb_i, mN_we_i  input  1 each  strobe and write enable from master N.
REQ-006 mN_addr_i, mN_dat_i  input  32 each  address and write data from master N.
REQ-007 mN_sel_i  input  4  byte select from master N.
REQ-008 mN_cti_i  input  3  cycle type identifier from master N.
REQ-009 mN_dat_o  output  32  read data to master N.
REQ-010 mN_ack_o, mN_err_o  output  1 each  acknowledge and timeout error to master N.
REQ-011 s_cyc_o, s_stb_o, s_we_o  output  1 each  cycle, strobe and write enable to the shared slave (SDRAM controller Wishbone port).
REQ-012 s_addr_o, s_dat_o  output  32 each; s_sel_o  output  4; s_cti_o  output  3  forwarded from the granted master.
REQ-013 s_dat_i, s_ack_i  input  32, 1  read data and acknowledge from the slave.
REQ-014 grant_o  output  2  one-hot grant status: bit N set while master N owns the slave.

Function
REQ-015 The state machine SHALL have four states: IDLE, GNT0, GNT1, ABORT.
REQ-016 IDLE: no cyc request -> stay; one request -> GNTN of the requester on the next edge; both -> GNT of the master not served last (round-robin pointer).
REQ-017 The round-robin pointer SHALL update on entry to GNTN to record N as last served.
REQ-018 Grant latency: mN_cyc_i rising in IDLE at cycle k -> s_cyc_o high at cycle k+1; no transfer is forwarded in the arbitration cycle.
REQ-019 In GNTN, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o SHALL equal master N's inputs combinationally; the other master's requests are ignored.
REQ-020 In GNTN, mN_ack_o = s_ack_i combinationally; the non-granted master's ack_o and err_o are 0.
REQ-021 m0_dat_o and m1_dat_o SHALL both equal s_dat_i at all times.
REQ-022 Grant SHALL be held for the whole bus cycle, including incrementing bursts (cti 3'b010) and the end-of-burst beat (cti 3'b111), until mN_cyc_i deasserts.
REQ-023 GNTN -> IDLE on the edge where mN_cyc_i is sampled low; s_cyc_o follows mN_cyc_i low in that same cycle.
REQ-024 Back-to-back: if the other master is waiting when a grant is released, it SHALL be granted after exactly one IDLE cycle; a lone master re-requesting also passes through one IDLE cycle.
REQ-025 Wait counter (16 bits): cleared in IDLE, on s_ack_i, and whenever s_stb_o is low; incremented each GNTN cycle with s_stb_o high and s_ack_i low; saturates, never wraps.
REQ-026 When the counter reaches TIMEOUT-1 with s_ack_i still low, mN_err_o SHALL pulse high for exactly that cycle and the next state SHALL be ABORT.
REQ-027 ABORT: all s_* outputs 0, grant_o keeps bit N; stay until mN_cyc_i is sampled low, then IDLE.
REQ-028 s_ack_i arriving in the same cycle the counter hits TIMEOUT-1 SHALL win: ack forwarded, no error, counter cleared.
REQ-029 s_ack_i while in IDLE or ABORT SHALL be ignored (no ack to either master).

Reset
REQ-030 wb_rst_i sampled high in any state SHALL force IDLE at that edge: round-robin pointer = master 1 (so master 0 wins first tie), counter 0, grant_o 2'b00.
REQ-031 While in IDLE/reset: all s_* outputs 0, mN_ack_o 0, mN_err_o 0; mN_dat_o = s_dat_i.
REQ-032 Reset mid-transfer SHALL drop s_cyc_o at the next edge without error pulses; an ack from the slave in the following cycle is ignored.

Verification
REQ-033 m0 single write addr 0x0000_0010 data 0xDEAD_BEEF sel 4'hF, slave acks after 3 waits -> s_cyc_o at k+1, s_addr_o/s_dat_o match, m0_ack_o one cycle, grant_o 2'b01 then 2'b00.
REQ-034 m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; m1 granted exactly one IDLE cycle after m0 drops cyc; next simultaneous request grants m0 again.
REQ-035 m1 4-beat read burst (cti 010,010,010,111), s_dat_i 0x1..0x4, while m0 requests mid-burst -> m1 receives 4 acks with data 0x1..0x4; m0 not granted until m1 cyc low.
REQ-036 TIMEOUT=8, m0 read, slave never acks -> m1/m0 ack stay 0, m0_err_o high in the 8th wait cycle only, s_cyc_o low in ABORT, IDLE after m0 drops cyc.
REQ-037 TIMEOUT=8, ack arrives in the 8th wait cycle -> m0_ack_o high, m0_err_o stays 0.
REQ-038 wb_rst_i asserted one cycle during m1 burst beat 2 -> s_cyc_o 0 at next edge, grant_o 2'b00, no err pulses, late s_ack_i ignored.
